k12a_uart_loader: RTL and testbench

- Host programming front-end that sits directly upstream of the k12a core.
- Receives load frames over a UART and emits byte writes (address, data, write strobe) into program/data memory.
- Holds the core in reset with its own cpu_reset_n output while a load is in progress, and releases it on a RUN command.
- Returns a one-byte ACK or NAK to the host for each frame.

---
 rtl/k12a_uart_loader_pkg.sv | 25 ++
 rtl/k12a_uart_rx.sv | 78 +++++++
 rtl/k12a_uart_loader.sv | 174 +++++++++++++++++
 tb/tb_k12a_uart_loader.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/k12a_uart_loader_pkg.sv
// Shared k12a types and constants for the UART program loader.
package k12a_uart_loader_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ADDR_HI,
    ST_ADDR_LO,
    ST_LEN,
    ST_DATA,
    ST_CSUM
  } loader_state_t;

  typedef enum logic [1:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_STOP
  } rx_state_t;

  localparam logic [7:0] LDR_SYNC = 8'h55;
  localparam logic [7:0] LDR_RUN  = 8'hAA;
  localparam logic [7:0] LDR_ACK  = 8'h06;
  localparam logic [7:0] LDR_NAK  = 8'h15;

endpackage

// File: rtl/k12a_uart_rx.sv
// UART 8N1 receiver: synchroniser, glitch-rejecting start, mid-bit sampling.
module k12a_uart_rx
  import k12a_uart_loader_pkg::*;
#(
  parameter int CLKS_PER_BIT = 16
) (
  input  logic       cpu_clock,
  input  logic       reset_n,
  input  logic       uart_rx,
  output logic       rx_valid,
  output logic       rx_ferr,
  output logic [7:0] rx_data
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] HALF = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

  rx_state_t     st;
  logic [1:0]    sync_q;
  logic          prev_q;
  logic [CW-1:0] cnt;
  logic [2:0]    bitn;

  always_ff @(posedge cpu_clock or negedge reset_n) begin
    if (!reset_n) begin
      st       <= RX_IDLE;
      sync_q   <= 2'b11;
      prev_q   <= 1'b1;
      cnt      <= '0;
      bitn     <= '0;
      rx_data  <= '0;
      rx_valid <= 1'b0;
      rx_ferr  <= 1'b0;
    end else begin
      sync_q   <= {sync_q[0], uart_rx};
      prev_q   <= sync_q[1];
      rx_valid <= 1'b0;
      rx_ferr  <= 1'b0;
      unique case (st)
        RX_IDLE: begin
          cnt <= '0;
          if (prev_q && !sync_q[1]) st <= RX_START;
        end
        RX_START: begin
          if (cnt == HALF) begin
            cnt  <= '0;
            bitn <= '0;
            st   <= sync_q[1] ? RX_IDLE : RX_DATA;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        RX_DATA: begin
          if (cnt == LAST) begin
            cnt     <= '0;
            rx_data <= {sync_q[1], rx_data[7:1]};
            if (bitn == 3'd7) st <= RX_STOP;
            else bitn <= bitn + 3'd1;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        RX_STOP: begin
          if (cnt == LAST) begin
            cnt      <= '0;
            st       <= RX_IDLE;
            rx_valid <= sync_q[1];
            rx_ferr  <= !sync_q[1];
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
      endcase
    end
  end

endmodule

// File: rtl/k12a_uart_loader.sv
// Host UART loader for k12a: frame parser, memory writer, core hold, ACK/NAK TX.
module k12a_uart_loader
  import k12a_uart_loader_pkg::*;
#(
  parameter int CLKS_PER_BIT  = 16,
  parameter bit HOLD_AT_RESET = 1'b1
) (
  input  logic        cpu_clock,
  input  logic        reset_n,
  input  logic        uart_rx,
  output logic        uart_tx,
  output logic        cpu_reset_n,
  output logic        prog_we,
  output logic [15:0] prog_addr,
  output logic [7:0]  prog_data,
  output logic        loading,
  output logic        error
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

  logic       rx_valid;
  logic       rx_ferr;
  logic [7:0] rx_data;

  k12a_uart_rx #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_rx (
    .cpu_clock(cpu_clock),
    .reset_n  (reset_n),
    .uart_rx  (uart_rx),
    .rx_valid (rx_valid),
    .rx_ferr  (rx_ferr),
    .rx_data  (rx_data)
  );

  loader_state_t state;
  logic [15:0]   addr;
  logic [8:0]    remain;
  logic [7:0]    sum;
  logic          resp_req;
  logic [7:0]    resp_byte;

  always_ff @(posedge cpu_clock or negedge reset_n) begin
    if (!reset_n) begin
      state       <= ST_IDLE;
      cpu_reset_n <= !HOLD_AT_RESET;
      prog_we     <= 1'b0;
      prog_addr   <= '0;
      prog_data   <= '0;
      loading     <= 1'b0;
      error       <= 1'b0;
      addr        <= '0;
      remain      <= '0;
      sum         <= '0;
      resp_req    <= 1'b0;
      resp_byte   <= '0;
    end else begin
      prog_we  <= 1'b0;
      resp_req <= 1'b0;
      if (rx_ferr && state != ST_IDLE) begin
        state     <= ST_IDLE;
        error     <= 1'b1;
        loading   <= 1'b0;
        resp_req  <= 1'b1;
        resp_byte <= LDR_NAK;
      end else if (rx_valid) begin
        unique case (state)
          ST_IDLE: begin
            unique case (1'b1)
              (rx_data == LDR_SYNC): begin
                state       <= ST_ADDR_HI;
                loading     <= 1'b1;
                cpu_reset_n <= 1'b0;
                error       <= 1'b0;
                sum         <= '0;
              end
              (rx_data == LDR_RUN): begin
                cpu_reset_n <= 1'b1;
                resp_req    <= 1'b1;
                resp_byte   <= LDR_ACK;
              end
              default: ;
            endcase
          end
          ST_ADDR_HI: begin
            addr[15:8] <= rx_data;
            sum        <= sum + rx_data;
            state      <= ST_ADDR_LO;
          end
          ST_ADDR_LO: begin
            addr[7:0] <= rx_data;
            sum       <= sum + rx_data;
            state     <= ST_LEN;
          end
          ST_LEN: begin
            remain <= (rx_data == 8'd0) ? 9'd256 : {1'b0, rx_data};
            sum    <= sum + rx_data;
            state  <= ST_DATA;
          end
          ST_DATA: begin
            prog_we   <= 1'b1;
            prog_addr <= addr;
            prog_data <= rx_data;
            addr      <= addr + 16'd1;
            sum       <= sum + rx_data;
            remain    <= remain - 9'd1;
            if (remain == 9'd1) state <= ST_CSUM;
          end
          ST_CSUM: begin
            state    <= ST_IDLE;
            loading  <= 1'b0;
            resp_req <= 1'b1;
            if (rx_data == sum) begin
              resp_byte <= LDR_ACK;
            end else begin
              resp_byte <= LDR_NAK;
              error     <= 1'b1;
            end
          end
          default: state <= ST_IDLE;
        endcase
      end
    end
  end

  logic          tx_busy;
  logic [CW-1:0] tx_cnt;
  logic [3:0]    tx_bitn;
  logic [8:0]    tx_shift;
  logic          pend_v;
  logic [7:0]    pend_byte;

  // shift holds {stop, data}; the start bit is driven on load
  always_ff @(posedge cpu_clock or negedge reset_n) begin
    if (!reset_n) begin
      uart_tx   <= 1'b1;
      tx_busy   <= 1'b0;
      tx_cnt    <= '0;
      tx_bitn   <= '0;
      tx_shift  <= '1;
      pend_v    <= 1'b0;
      pend_byte <= '0;
    end else begin
      if (tx_busy) begin
        if (tx_cnt == LAST) begin
          tx_cnt <= '0;
          if (tx_bitn == 4'd9) begin
            tx_busy <= 1'b0;
          end else begin
            uart_tx  <= tx_shift[0];
            tx_shift <= {1'b1, tx_shift[8:1]};
            tx_bitn  <= tx_bitn + 4'd1;
          end
        end else begin
          tx_cnt <= tx_cnt + 1'b1;
        end
      end else if (pend_v) begin
        tx_busy  <= 1'b1;
        uart_tx  <= 1'b0;
        tx_shift <= {1'b1, pend_byte};
        tx_cnt   <= '0;
        tx_bitn  <= '0;
        pend_v   <= 1'b0;
      end
      if (resp_req) begin
        pend_v    <= 1'b1;
        pend_byte <= resp_byte;
      end
    end
  end

endmodule

// File: tb/tb_k12a_uart_loader.sv
// Randomised frame-level bench for k12a_uart_loader with a frame reference model.
module tb_k12a_uart_loader;

  localparam int CPB = 8;

  logic        cpu_clock = 1'b0;
  logic        reset_n   = 1'b0;
  logic        uart_rx   = 1'b1;
  logic        uart_tx;
  logic        cpu_reset_n;
  logic        prog_we;
  logic [15:0] prog_addr;
  logic [7:0]  prog_data;
  logic        loading;
  logic        error;

  always #5 cpu_clock = ~cpu_clock;

  k12a_uart_loader #(
    .CLKS_PER_BIT (CPB),
    .HOLD_AT_RESET(1'b1)
  ) dut (
    .cpu_clock  (cpu_clock),
    .reset_n    (reset_n),
    .uart_rx    (uart_rx),
    .uart_tx    (uart_tx),
    .cpu_reset_n(cpu_reset_n),
    .prog_we    (prog_we),
    .prog_addr  (prog_addr),
    .prog_data  (prog_data),
    .loading    (loading),
    .error      (error)
  );

  int n_cmp = 0;
  int n_bad = 0;

  logic [23:0] got_wr[$];
  logic [23:0] exp_wr[$];
  logic [7:0]  got_rsp[$];
  logic [7:0]  pl[$];

  int we_long   = 0;
  int we_run    = 0;
  int load_drop = 0;
  bit prev_we   = 1'b0;
  bit in_frame  = 1'b0;

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  always @(negedge cpu_clock) begin
    if (prog_we === 1'b1) begin
      got_wr.push_back({prog_addr, prog_data});
      if (prev_we) we_long++;
      if (cpu_reset_n !== 1'b0) we_run++;
    end
    if (in_frame && loading !== 1'b1) load_drop++;
    prev_we = (prog_we === 1'b1);
  end

  initial begin
    logic [7:0] b;
    forever begin
      @(negedge cpu_clock);
      if (uart_tx === 1'b0) begin
        repeat (CPB / 2) @(negedge cpu_clock);
        for (int i = 0; i < 8; i++) begin
          repeat (CPB) @(negedge cpu_clock);
          b[i] = uart_tx;
        end
        repeat (CPB) @(negedge cpu_clock);
        got_rsp.push_back(b);
      end
    end
  end

  task automatic send_byte(input logic [7:0] b, input bit stop_ok = 1'b1);
    uart_rx = 1'b0;
    repeat (CPB) @(posedge cpu_clock);
    for (int i = 0; i < 8; i++) begin
      uart_rx = b[i];
      repeat (CPB) @(posedge cpu_clock);
    end
    uart_rx = stop_ok;
    repeat (CPB) @(posedge cpu_clock);
    uart_rx = 1'b1;
    repeat (4) @(posedge cpu_clock);
  endtask

  task automatic wait_rsp(input string tag, input logic [7:0] want);
    int t = 0;
    while (got_rsp.size() == 0 && t < 24 * CPB) begin
      @(negedge cpu_clock);
      t++;
    end
    check({tag, "_rspn"}, got_rsp.size(), 1);
    if (got_rsp.size() > 0) check({tag, "_rsp"}, got_rsp.pop_front(), want);
  endtask

  task automatic cmp_wr(input string tag);
    int bad = 0;
    check({tag, "_wrn"}, got_wr.size(), exp_wr.size());
    for (int i = 0; i < exp_wr.size() && i < got_wr.size(); i++)
      if (got_wr[i] !== exp_wr[i]) bad++;
    check({tag, "_wrd"}, bad, 0);
    got_wr.delete();
    exp_wr.delete();
  endtask

  task automatic send_run(input string tag);
    send_byte(8'hAA);
    check({tag, "_rel"}, cpu_reset_n, 1'b1);
    wait_rsp(tag, 8'h06);
  endtask

  // Payload comes from pl; csum_ovr < 0 sends the correct checksum
  task automatic frame(input string tag, input logic [15:0] a,
                       input logic [7:0] lb, input int csum_ovr,
                       input bit glitch);
    logic [7:0] cs;
    logic [7:0] tx_cs;
    int n;
    bit good;
    n  = (lb == 8'd0) ? 256 : int'(lb);
    cs = a[15:8] + a[7:0] + lb;
    for (int i = 0; i < n; i++) begin
      cs = cs + pl[i];
      exp_wr.push_back({a + 16'(i), pl[i]});
    end
    tx_cs = (csum_ovr < 0) ? cs : csum_ovr[7:0];
    good  = (tx_cs == cs);
    send_byte(8'h55);
    check({tag, "_load"}, loading, 1'b1);
    check({tag, "_hold"}, cpu_reset_n, 1'b0);
    check({tag, "_eclr"}, error, 1'b0);
    in_frame = 1'b1;
    send_byte(a[15:8]);
    if (glitch) begin
      @(posedge cpu_clock);
      uart_rx = 1'b0;
      @(posedge cpu_clock);
      uart_rx = 1'b1;
      repeat (3 * CPB) @(posedge cpu_clock);
    end
    send_byte(a[7:0]);
    send_byte(lb);
    for (int i = 0; i < n; i++) send_byte(pl[i]);
    in_frame = 1'b0;
    send_byte(tx_cs);
    wait_rsp(tag, good ? 8'h06 : 8'h15);
    check({tag, "_err"}, error, !good);
    check({tag, "_ldoff"}, loading, 1'b0);
    check({tag, "_held"}, cpu_reset_n, 1'b0);
    cmp_wr(tag);
  endtask

  task automatic rand_pl(input int n);
    pl.delete();
    for (int i = 0; i < n; i++) pl.push_back(8'($urandom));
  endtask

  initial begin
    logic [15:0] ra;
    int rl;
    repeat (3) @(posedge cpu_clock);
    #1;
    check("rst_in", {cpu_reset_n, uart_tx, prog_we, loading, error,
                     prog_addr, prog_data}, {1'b0, 1'b1, 3'b000, 24'h0});
    reset_n = 1'b1;
    repeat (4) @(negedge cpu_clock);
    check("rst_out", {cpu_reset_n, uart_tx, prog_we, loading, error,
                      prog_addr, prog_data}, {1'b0, 1'b1, 3'b000, 24'h0});

    send_run("run0");
    check("run0_ld", loading, 1'b0);

    pl = '{8'hA1, 8'hB2, 8'hC3};
    frame("ex_ok", 16'h1234, 8'd3, -1, 1'b0);
    frame("ex_bad", 16'h1234, 8'd3, 0, 1'b0);

    pl = '{8'h11, 8'h22};
    frame("wrap", 16'hFFFF, 8'd2, -1, 1'b0);

    rand_pl(256);
    frame("len0", 16'($urandom), 8'd0, -1, 1'b0);

    send_byte(8'h55);
    send_byte(8'h12);
    send_byte(8'h34, 1'b0);
    wait_rsp("ferr", 8'h15);
    check("ferr_err", error, 1'b1);
    check("ferr_ld", loading, 1'b0);
    cmp_wr("ferr");

    rand_pl(3);
    frame("glitch", 16'h0A0B, 8'd3, -1, 1'b1);

    for (int f = 0; f < 6; f++) begin
      if ($urandom_range(0, 1) == 1) send_run("rrun");
      ra = 16'($urandom);
      rl = $urandom_range(1, 6);
      rand_pl(rl);
      frame("rnd", ra, 8'(rl),
            ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 255)) : -1,
            1'b0);
    end

    send_byte(8'h55);
    send_byte(8'h40);
    send_byte(8'h00);
    send_byte(8'h04);
    send_byte(8'h9A);
    send_byte(8'h7C);
    exp_wr.push_back({16'h4000, 8'h9A});
    exp_wr.push_back({16'h4001, 8'h7C});
    uart_rx = 1'b0;
    repeat (3 * CPB) @(posedge cpu_clock);
    #2 reset_n = 1'b0;
    #1;
    check("rst_mid", {cpu_reset_n, uart_tx, prog_we, loading, error,
                      prog_addr, prog_data}, {1'b0, 1'b1, 3'b000, 24'h0});
    uart_rx = 1'b1;
    cmp_wr("rst_pre");
    repeat (3) @(posedge cpu_clock);
    reset_n = 1'b1;
    repeat (2 * CPB) @(posedge cpu_clock);
    rand_pl(4);
    frame("post_rst", 16'($urandom), 8'd4, -1, 1'b0);

    repeat (12 * CPB) @(negedge cpu_clock);
    check("extra_rsp", got_rsp.size(), 0);
    check("we_1cyc", we_long, 0);
    check("we_run", we_run, 0);
    check("load_hi", load_drop, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
